serial_loader: RTL and testbench
================================

Name: serial_loader

Overview:
- UART-driven monitor stage directly upstream of the cpu. It parses single-byte commands from the UART receiver.
- It loads program bytes into RAM, dumps RAM back over UART, and controls the cpu's reset, halt and start_address.
- It owns the RAM ports only while the cpu is halted; the top level muxes RAM ports on mem_owner.

Parameters:
- addr_width, 9, RAM address bits; must match the cpu's addr_width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle strobe to UART transmitter
- tx_busy  in  1  transmitter busy
- mem_data_out  in  8  RAM read data (from memory)
- mem_data_in  out  8  RAM write data (to memory)
- mem_raddr  out  addr_width  RAM read address
- mem_waddr  out  addr_width  RAM write address
- mem_write  out  1  RAM write enable, one-cycle pulses
- mem_owner  out  1  1 = loader drives RAM ports
- cpu_reset  out  1  reset to cpu
- cpu_halt  out  1  halt request to cpu
- cpu_halted  in  1  cpu halted status
- start_address  out  addr_width  cpu start address

Behaviour:
- Reset values:
  - state IDLE; cpu_halt=1; cpu_reset=0; mem_owner=1; mem_write=0; tx_start=0.
  - tx_data=0, mem_*addr=0, mem_data_in=0, start_address=0.
- Reset mid-command aborts it; no ack is sent.
- Protocol: all multi-byte fields are big-endian 16 bit; addresses are truncated to addr_width.
- Commands:
  - 'L'(0x4C) addrH addrL lenH lenL data[len]: writes bytes to addr, addr+1, …
  - 'D'(0x44) addrH addrL lenH lenL: replies with len bytes read from addr.
  - 'X'(0x58) addrH addrL: start_address<=addr; cpu_reset high for exactly 2 cycles; then cpu_halt<=0 and mem_owner<=0 on the same cycle.
  - 'H'(0x48): cpu_halt<=1; waits until cpu_halted=1, then mem_owner<=1.
  - 'S'(0x53): replies {7'b0, cpu_halted}.
- Ack rules:
  - Every completed command ends with ack '!'(0x21).
  - 'D' and 'S' send the ack after their data.
  - An unknown command byte gets '?'(0x3F) and returns to IDLE.
- 'L'/'D' with mem_owner=0: still consume all their bytes ('L' includes the data), perform no RAM access, reply '?'.
- len=0: no RAM access, immediate '!'.
- Address wrap: the running address increments modulo 2^addr_width.
- Write timing: mem_waddr and mem_data_in are set on the cycle after rx_valid; mem_write pulses on the following cycle; 1 write per received byte.
- Read timing (2-cycle RAM latency):
  - RDADDR sets mem_raddr; RDWAIT; RDCAP latches mem_data_out into tx_data.
  - SEND pulses tx_start only when tx_busy=0; SENDWAIT waits for tx_busy to rise, then fall.
- TX rule: tx_start is never asserted while tx_busy=1.
- rx_valid during a reply phase (D dump, ack) is ignored; the byte is dropped.
- FSM states:
  - IDLE, CMD, ADDRH, ADDRL, LENH, LENL, LDATA, WRITE, RDADDR, RDWAIT, RDCAP, SEND, SENDWAIT, ACK, ACKWAIT, START, HALTWAIT.
- Transitions:
  - IDLE -rx_valid-> CMD.
  - CMD decodes: L/D/X -> ADDRH; H -> HALTWAIT; S -> SEND; else -> ACK with '?'.
  - ADDRL: X -> START; L/D -> LENH.
  - LENL: len=0 -> ACK; L -> LDATA; D -> RDADDR.
  - WRITE: len-1=0 -> ACK, else -> LDATA.
  - SENDWAIT: dump remaining -> RDADDR, else -> ACK.
  - START (2 cycles) -> ACK.
  - HALTWAIT -cpu_halted-> ACK.
  - ACKWAIT -> IDLE.
- Length counter is 16 bit, decremented once per byte transferred.

Decomposition:
- Shared package: command byte constants (CMD_LOAD, CMD_DUMP, CMD_EXEC, CMD_HALT, CMD_STAT), ACK/NAK bytes, state encoding localparams.
- Sub-module: loader_tx_ctl, the tx_start/tx_busy handshake (idle→pulse→wait busy rise→wait busy fall).

Test Plan:
- Reset, then 'S' with cpu_halted=1 -> tx bytes 0x01, 0x21; cpu_halt=1, mem_owner=1 throughout.
- 'L' 00 10 00 03 AA BB CC -> exactly 3 mem_write pulses at waddr 0x010/0x011/0x012 with data AA/BB/CC; then tx 0x21.
- After the load: 'D' 00 10 00 03 with a RAM model -> tx AA BB CC 21; raddr 0x010..0x012; tx_start never asserted while tx_busy=1.
- 'L' 01 FF 00 02 11 22 (addr_width=9) -> writes at 0x1FF, then 0x000 (wrap); len=0 load -> no write, 0x21.
- 'X' 00 20 -> start_address=0x020; cpu_reset high 2 cycles; cpu_halt and mem_owner fall together; then 'D' 00 00 00 01 -> no RAM read, tx 0x3F.
- 'H', with cpu_halted held low 5 cycles then high -> mem_owner rises after cpu_halted, tx 0x21; unknown byte 0x7A -> 0x3F; reset asserted mid-'L' -> no further writes, state IDLE.

Source files
------------

// File: rtl/serial_loader_pkg.sv
// rtl/serial_loader_pkg.sv - command bytes, reply bytes and state types for the serial loader
package serial_loader_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_DUMP = 8'h44;
   localparam logic [7:0] CMD_EXEC = 8'h58;
   localparam logic [7:0] CMD_HALT = 8'h48;
   localparam logic [7:0] CMD_STAT = 8'h53;
   localparam logic [7:0] ACK_BYTE = 8'h21;
   localparam logic [7:0] NAK_BYTE = 8'h3F;

   typedef enum logic [4:0] {
      IDLE, CMD, ADDRH, ADDRL, LENH, LENL, LDATA, WRITE,
      RDADDR, RDWAIT, RDCAP, SEND, SENDWAIT, ACK, ACKWAIT, START, HALTWAIT
   } loader_state_t;

   typedef enum logic [1:0] {
      TX_IDLE, TX_PULSE, TX_RISE, TX_FALL
   } tx_state_t;

   function automatic logic takes_addr(input logic [7:0] c);
      return (c == CMD_LOAD) || (c == CMD_DUMP) || (c == CMD_EXEC);
   endfunction

   function automatic logic is_known(input logic [7:0] c);
      return takes_addr(c) || (c == CMD_HALT) || (c == CMD_STAT);
   endfunction

endpackage

// File: rtl/loader_tx_ctl.sv
// rtl/loader_tx_ctl.sv - one-byte handshake toward the UART transmitter
module loader_tx_ctl
   import serial_loader_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic busy,
   output logic start,
   output logic accept,
   output logic done
);

   tx_state_t state, state_next;

   always_ff @(posedge clk) begin
      if (reset) state <= TX_IDLE;
      else       state <= state_next;
   end

   // A byte is only taken while the transmitter is idle, so start never meets busy.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      done       = 1'b0;
      case (state)
         TX_IDLE: begin
            if (req && !busy) begin
               accept     = 1'b1;
               state_next = TX_PULSE;
            end
         end
         TX_PULSE: state_next = TX_RISE;
         TX_RISE:  if (busy) state_next = TX_FALL;
         TX_FALL: begin
            if (!busy) begin
               done       = 1'b1;
               state_next = TX_IDLE;
            end
         end
         default: state_next = TX_IDLE;
      endcase
   end

   assign start = (state == TX_PULSE);

endmodule

// File: rtl/serial_loader.sv
// rtl/serial_loader.sv - UART command monitor: loads/dumps RAM and controls cpu reset, halt and start address
module serial_loader
   import serial_loader_pkg::*;
#(
   parameter int addr_width = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   input  logic                  tx_busy,
   input  logic [7:0]            mem_data_out,
   output logic [7:0]            mem_data_in,
   output logic [addr_width-1:0] mem_raddr,
   output logic [addr_width-1:0] mem_waddr,
   output logic                  mem_write,
   output logic                  mem_owner,
   output logic                  cpu_reset,
   output logic                  cpu_halt,
   input  logic                  cpu_halted,
   output logic [addr_width-1:0] start_address
);

   loader_state_t         state, state_next;
   logic [7:0]            cmd;
   logic [7:0]            hi;
   logic [7:0]            ack_code;
   logic [addr_width-1:0] addr;
   logic [15:0]           len;
   logic                  start_cnt;
   logic                  tx_req, tx_accept, tx_done;

   loader_tx_ctl u_tx_ctl (
      .clk    (clk),
      .reset  (reset),
      .req    (tx_req),
      .busy   (tx_busy),
      .start  (tx_start),
      .accept (tx_accept),
      .done   (tx_done)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      tx_req     = 1'b0;
      case (state)
         IDLE: if (rx_valid) state_next = CMD;
         CMD: begin
            if (takes_addr(cmd))       state_next = ADDRH;
            else if (cmd == CMD_HALT)  state_next = HALTWAIT;
            else if (cmd == CMD_STAT)  state_next = SEND;
            else                       state_next = ACK;
         end
         ADDRH: if (rx_valid) state_next = ADDRL;
         ADDRL: if (rx_valid) state_next = (cmd == CMD_EXEC) ? START : LENH;
         LENH:  if (rx_valid) state_next = LENL;
         LENL: begin
            if (rx_valid) begin
               if ({hi, rx_data} == 16'd0) state_next = ACK;
               else if (cmd == CMD_LOAD)   state_next = LDATA;
               else if (mem_owner)         state_next = RDADDR;
               else                        state_next = ACK;
            end
         end
         LDATA:  if (rx_valid) state_next = WRITE;
         WRITE:  state_next = (len == 16'd1) ? ACK : LDATA;
         RDADDR: state_next = RDWAIT;
         RDWAIT: state_next = RDCAP;
         RDCAP:  state_next = SEND;
         SEND: begin
            tx_req = 1'b1;
            if (tx_accept) state_next = SENDWAIT;
         end
         SENDWAIT: begin
            if (tx_done) state_next = (cmd == CMD_DUMP && len != 16'd0) ? RDADDR : ACK;
         end
         ACK: begin
            tx_req = 1'b1;
            if (tx_accept) state_next = ACKWAIT;
         end
         ACKWAIT:  if (tx_done) state_next = IDLE;
         START:    if (start_cnt) state_next = ACK;
         HALTWAIT: if (cpu_halted) state_next = ACK;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd           <= 8'h00;
         hi            <= 8'h00;
         ack_code      <= ACK_BYTE;
         addr          <= '0;
         len           <= 16'd0;
         start_cnt     <= 1'b0;
         tx_data       <= 8'h00;
         mem_data_in   <= 8'h00;
         mem_raddr     <= '0;
         mem_waddr     <= '0;
         mem_write     <= 1'b0;
         mem_owner     <= 1'b1;
         cpu_reset     <= 1'b0;
         cpu_halt      <= 1'b1;
         start_address <= '0;
      end else begin
         mem_write <= 1'b0;
         case (state)
            IDLE: if (rx_valid) cmd <= rx_data;
            CMD: begin
               // RAM commands issued while the cpu owns memory are still parsed, then refused.
               if (!is_known(cmd) || ((cmd == CMD_LOAD || cmd == CMD_DUMP) && !mem_owner))
                  ack_code <= NAK_BYTE;
               else
                  ack_code <= ACK_BYTE;
               if (cmd == CMD_HALT) cpu_halt <= 1'b1;
            end
            ADDRH, LENH: if (rx_valid) hi <= rx_data;
            ADDRL: begin
               if (rx_valid) begin
                  addr <= addr_width'({hi, rx_data});
                  if (cmd == CMD_EXEC) begin
                     start_address <= addr_width'({hi, rx_data});
                     cpu_reset     <= 1'b1;
                     start_cnt     <= 1'b0;
                  end
               end
            end
            LENL: if (rx_valid) len <= {hi, rx_data};
            LDATA: begin
               if (rx_valid && mem_owner) begin
                  mem_waddr   <= addr;
                  mem_data_in <= rx_data;
               end
            end
            WRITE: begin
               mem_write <= mem_owner;
               addr      <= addr + addr_width'(1);
               len       <= len - 16'd1;
            end
            RDADDR: mem_raddr <= addr;
            RDCAP: begin
               tx_data <= mem_data_out;
               addr    <= addr + addr_width'(1);
               len     <= len - 16'd1;
            end
            SEND: if (cmd == CMD_STAT) tx_data <= {7'b0, cpu_halted};
            ACK:  tx_data <= ack_code;
            START: begin
               start_cnt <= 1'b1;
               if (start_cnt) begin
                  cpu_reset <= 1'b0;
                  cpu_halt  <= 1'b0;
                  mem_owner <= 1'b0;
               end
            end
            HALTWAIT: if (cpu_halted) mem_owner <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_loader.sv
// tb/tb_serial_loader.sv - randomized scoreboard bench for serial_loader with RAM and UART models
module tb_serial_loader;

   localparam int AW    = 9;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset, rx_valid, tx_start, tx_busy, mem_write, mem_owner;
   logic          cpu_reset, cpu_halt, cpu_halted;
   logic [7:0]    rx_data, tx_data, mem_data_out, mem_data_in;
   logic [AW-1:0] mem_raddr, mem_waddr, start_address;

   always #5 clk = ~clk;

   serial_loader #(.addr_width(AW)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .tx_data       (tx_data),
      .tx_start      (tx_start),
      .tx_busy       (tx_busy),
      .mem_data_out  (mem_data_out),
      .mem_data_in   (mem_data_in),
      .mem_raddr     (mem_raddr),
      .mem_waddr     (mem_waddr),
      .mem_write     (mem_write),
      .mem_owner     (mem_owner),
      .cpu_reset     (cpu_reset),
      .cpu_halt      (cpu_halt),
      .cpu_halted    (cpu_halted),
      .start_address (start_address)
   );

   int checks = 0;
   int errors = 0;
   int wr_seen = 0;

   typedef struct {
      logic [7:0]    data;
      bit            chk_addr;
      logic [AW-1:0] raddr;
   } tx_exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_exp_t;

   tx_exp_t    exp_tx[$];
   wr_exp_t    exp_wr[$];
   logic [7:0] m_mem [DEPTH];
   logic [7:0] ram [DEPTH];
   bit         m_owner;
   logic [7:0] cmd_q[$];
   tx_exp_t    mon_tx;
   wr_exp_t    mon_wr;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Synchronous RAM: the read data appears one edge after mem_raddr is sampled.
   always @(posedge clk) begin
      if (mem_write) ram[mem_waddr] <= mem_data_in;
      mem_data_out <= ram[mem_raddr];
   end

   // UART transmitter: busy rises the cycle after tx_start and lasts a random time.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat ($urandom_range(2, 6)) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && tx_start) begin
         check("tx_start_while_busy", int'(tx_busy), 0);
         if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx: got 0x%02h, expected no byte", tx_data);
         end else begin
            mon_tx = exp_tx.pop_front();
            check("tx_byte", int'(tx_data), int'(mon_tx.data));
            if (mon_tx.chk_addr) check("dump_raddr", int'(mem_raddr), int'(mon_tx.raddr));
         end
      end
      if (!reset && mem_write) begin
         wr_seen++;
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%02h, expected no write", mem_waddr, mem_data_in);
         end else begin
            mon_wr = exp_wr.pop_front();
            check("write_addr", int'(mem_waddr), int'(mon_wr.addr));
            check("write_data", int'(mem_data_in), int'(mon_wr.data));
         end
      end
   end

   function automatic int wrap(input int a);
      return a % DEPTH;
   endfunction

   task automatic push_tx(input logic [7:0] d, input bit chk, input int ra);
      tx_exp_t e;
      e.data     = d;
      e.chk_addr = chk;
      e.raddr    = AW'(ra);
      exp_tx.push_back(e);
   endtask

   // Reference model: derives the replies and RAM writes of the command in cmd_q.
   task automatic model_cmd();
      int      a, n;
      wr_exp_t w;
      a = 0;
      n = 0;
      if (cmd_q.size() >= 3) a = int'({cmd_q[1], cmd_q[2]});
      if (cmd_q.size() >= 5) n = int'({cmd_q[3], cmd_q[4]});
      case (cmd_q[0])
         8'h4C: begin
            if (m_owner) begin
               for (int i = 0; i < n; i++) begin
                  w.addr = AW'(wrap(a + i));
                  w.data = cmd_q[5 + i];
                  exp_wr.push_back(w);
                  m_mem[wrap(a + i)] = cmd_q[5 + i];
               end
            end
            push_tx(m_owner ? 8'h21 : 8'h3F, 1'b0, 0);
         end
         8'h44: begin
            if (m_owner) begin
               for (int i = 0; i < n; i++) push_tx(m_mem[wrap(a + i)], 1'b1, wrap(a + i));
               push_tx(8'h21, 1'b0, 0);
            end else begin
               push_tx(8'h3F, 1'b0, 0);
            end
         end
         8'h58: begin
            push_tx(8'h21, 1'b0, 0);
            m_owner = 1'b0;
         end
         8'h48: begin
            push_tx(8'h21, 1'b0, 0);
            m_owner = 1'b1;
         end
         8'h53: begin
            push_tx({7'b0, cpu_halted}, 1'b0, 0);
            push_tx(8'h21, 1'b0, 0);
         end
         default: push_tx(8'h3F, 1'b0, 0);
      endcase
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic gap();
      tick($urandom_range(3, 8));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < 4000) begin
         tick(1);
         n++;
      end
      if (n >= 4000) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d tx and %0d writes outstanding, expected 0",
                  exp_tx.size(), exp_wr.size());
         exp_tx.delete();
         exp_wr.delete();
      end
      n = 0;
      while (tx_busy && n < 100) begin
         tick(1);
         n++;
      end
      tick(4);
   endtask

   task automatic run();
      model_cmd();
      foreach (cmd_q[i]) begin
         send_byte(cmd_q[i]);
         gap();
      end
      drain();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int  wr_before, rst_hi, ok, seen;
      bit  fell;
      logic prev_own;
      logic [AW-1:0] raddr_before;

      reset      = 1'b1;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      cpu_halted = 1'b1;
      m_owner    = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      tick(3);
      reset = 1'b0;
      @(negedge clk);
      check("rst_tx_start", int'(tx_start), 0);
      check("rst_tx_data", int'(tx_data), 0);
      check("rst_mem_write", int'(mem_write), 0);
      check("rst_mem_owner", int'(mem_owner), 1);
      check("rst_cpu_halt", int'(cpu_halt), 1);
      check("rst_cpu_reset", int'(cpu_reset), 0);
      check("rst_addrs", int'({mem_raddr, mem_waddr, start_address}), 0);
      check("rst_mem_data_in", int'(mem_data_in), 0);
      tick(1);

      cmd_q = {8'h53};
      run();
      check("stat_halt_owner", int'({cpu_halt, mem_owner}), 3);

      wr_before = wr_seen;
      cmd_q = {8'h4C, 8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
      run();
      check("load3_write_count", wr_seen - wr_before, 3);

      cmd_q = {8'h44, 8'h00, 8'h10, 8'h00, 8'h03};
      run();

      cmd_q = {8'h4C, 8'h01, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22};
      run();
      cmd_q = {8'h44, 8'h01, 8'hFF, 8'h00, 8'h02};
      run();

      wr_before = wr_seen;
      cmd_q = {8'h4C, 8'h00, 8'h30, 8'h00, 8'h00};
      run();
      check("load_len0_writes", wr_seen - wr_before, 0);
      cmd_q = {8'h44, 8'h00, 8'h30, 8'h00, 8'h00};
      run();

      cmd_q = {8'h58, 8'h00, 8'h20};
      model_cmd();
      send_byte(8'h58);
      gap();
      send_byte(8'h00);
      gap();
      send_byte(8'h20);
      rst_hi   = 0;
      fell     = 1'b0;
      prev_own = mem_owner;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (cpu_reset) rst_hi++;
         if (!fell && !cpu_halt) begin
            fell = 1'b1;
            check("exec_owner_fall", int'({prev_own, mem_owner}), 2);
         end
         prev_own = mem_owner;
      end
      check("exec_reset_cycles", rst_hi, 2);
      check("exec_halt_fell", int'(fell), 1);
      check("start_address", int'(start_address), 'h20);
      cpu_halted = 1'b0;
      drain();

      raddr_before = mem_raddr;
      cmd_q = {8'h44, 8'h00, 8'h00, 8'h00, 8'h01};
      run();
      check("dump_no_owner_raddr", int'(mem_raddr), int'(raddr_before));
      cmd_q = {8'h53};
      run();

      cmd_q = {8'h48};
      model_cmd();
      send_byte(8'h48);
      tick(1);
      ok = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (mem_owner || !cpu_halt) ok = 0;
      end
      check("halt_wait_owner_low", ok, 1);
      @(posedge clk);
      #2 cpu_halted = 1'b1;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (mem_owner) seen = 1;
      end
      check("halt_owner_rise", seen, 1);
      drain();

      cmd_q = {8'h7A};
      run();

      begin
         wr_exp_t w;
         logic [7:0] part[$];
         part = {8'h4C, 8'h00, 8'h40, 8'h00, 8'h05, 8'hAA, 8'hBB};
         w.addr = 'h40; w.data = 8'hAA; exp_wr.push_back(w); m_mem['h40] = 8'hAA;
         w.addr = 'h41; w.data = 8'hBB; exp_wr.push_back(w); m_mem['h41] = 8'hBB;
         foreach (part[i]) begin
            send_byte(part[i]);
            gap();
         end
      end
      reset = 1'b1;
      tick(2);
      reset   = 1'b0;
      m_owner = 1'b1;
      check("reset_mid_load_writes_done", exp_wr.size(), 0);
      wr_before = wr_seen;
      tick(30);
      check("reset_mid_load_no_writes", wr_seen - wr_before, 0);
      check("reset_mid_load_owner_halt", int'({mem_owner, cpu_halt}), 3);
      cmd_q = {8'h53};
      run();

      for (int it = 0; it < 24; it++) begin
         int a, n, off, dl;
         a = $urandom_range(0, 65535);
         n = $urandom_range(1, 6);
         cmd_q = {8'h4C, 8'(a >> 8), 8'(a), 8'h00, 8'(n)};
         for (int i = 0; i < n; i++) cmd_q.push_back(8'($urandom));
         run();
         off = $urandom_range(0, n - 1);
         dl  = $urandom_range(0, n - off);
         cmd_q = {8'h44, 8'((a + off) >> 8), 8'(a + off), 8'h00, 8'(dl)};
         run();
         if ($urandom_range(0, 3) == 0) begin
            cmd_q = {8'h53};
            run();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
